store_narrowing_buffer: RTL and testbench

Store-side counterpart of the load/immediate extension path. It accepts store requests from the MEM stage and narrows each source register value to byte, halfword or word. It aligns the narrowed value into the correct byte lanes of a 32-bit memory word and generates byte enables. Requests are queued in a small FIFO that drains to the data-memory write port over a valid/ready handshake; misaligned or illegal-size requests are rejected and flagged.

---
 rtl/store_narrowing_buffer_if.sv | 33 +++
 rtl/store_narrowing_buffer.sv | 116 +++++++++++
 tb/tb_store_narrowing_buffer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_narrowing_buffer_if.sv
// Store request / memory write-port bundle for store_narrowing_buffer.
// The slave side is the buffer; the master side is the MEM stage and data memory.
interface store_narrowing_buffer_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 4
);
    logic                         i_valid;
    logic                         o_ready;
    logic [ADDR_SIZE-1:0]         i_addr;
    logic [DATA_SIZE-1:0]         i_data;
    logic [1:0]                   i_size;
    logic                         o_misaligned;
    logic                         o_mem_valid;
    logic                         i_mem_ready;
    logic [ADDR_SIZE-1:0]         o_mem_addr;
    logic [DATA_SIZE-1:0]         o_mem_data;
    logic [DATA_SIZE/8-1:0]       o_mem_byte_en;
    logic [$clog2(DEPTH):0]       o_count;
    logic                         o_empty;

    modport slave (
        input  i_valid, i_addr, i_data, i_size, i_mem_ready,
        output o_ready, o_misaligned, o_mem_valid, o_mem_addr, o_mem_data,
               o_mem_byte_en, o_count, o_empty
    );

    modport master (
        output i_valid, i_addr, i_data, i_size, i_mem_ready,
        input  o_ready, o_misaligned, o_mem_valid, o_mem_addr, o_mem_data,
               o_mem_byte_en, o_count, o_empty
    );
endinterface

// File: rtl/store_narrowing_buffer.sv
// Store narrowing buffer: narrows SB/SH/SW data into byte lanes with byte enables,
// rejects misaligned/illegal stores, and queues legal ones in a FIFO toward data memory.
module store_narrowing_buffer #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    store_narrowing_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DATA_SIZE / 8;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    logic [ADDR_SIZE-1:0] addr_q [DEPTH];
    logic [DATA_SIZE-1:0] data_q [DEPTH];
    logic [BW-1:0]        be_q   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          misaligned_q;

    logic                 legal;
    logic [DATA_SIZE-1:0] nar_data;
    logic [BW-1:0]        nar_be;
    logic [ADDR_SIZE-1:0] word_addr;
    logic                 ready;
    logic                 empty;
    logic                 take;
    logic                 push;
    logic                 pop;

    always_comb begin
        legal    = 1'b0;
        nar_data = '0;
        nar_be   = '0;
        unique case (size_e'(bus.i_size))
            SIZE_B: begin
                legal    = 1'b1;
                nar_data = {4{bus.i_data[7:0]}};
                nar_be   = {{(BW-1){1'b0}}, 1'b1} << bus.i_addr[1:0];
            end
            SIZE_H: begin
                legal    = !bus.i_addr[0];
                nar_data = {2{bus.i_data[15:0]}};
                nar_be   = bus.i_addr[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_W: begin
                legal    = (bus.i_addr[1:0] == 2'b00);
                nar_data = bus.i_data;
                nar_be   = '1;
            end
            SIZE_X: begin
                legal = 1'b0;
            end
        endcase
    end

    assign word_addr = {bus.i_addr[ADDR_SIZE-1:2], 2'b00};

    // Ready looks only at the registered count, so a full buffer refuses even when popping.
    assign ready = (count < FULL_COUNT);
    assign empty = (count == '0);
    assign take  = bus.i_valid && ready;
    assign push  = take && legal;
    assign pop   = !empty && bus.i_mem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misaligned_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            misaligned_q <= take && !legal;
            if (push) begin
                addr_q[wr_ptr] <= word_addr;
                data_q[wr_ptr] <= nar_data;
                be_q[wr_ptr]   <= nar_be;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_misaligned  = misaligned_q;
    assign bus.o_mem_valid   = !empty;
    assign bus.o_count       = count;
    assign bus.o_empty       = empty;
    assign bus.o_mem_addr    = empty ? '0 : addr_q[rd_ptr];
    assign bus.o_mem_data    = empty ? '0 : data_q[rd_ptr];
    assign bus.o_mem_byte_en = empty ? '0 : be_q[rd_ptr];
endmodule

// File: tb/tb_store_narrowing_buffer.sv
// Directed bench for store_narrowing_buffer with a byte-lane reference model and FIFO scoreboard.
module tb_store_narrowing_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   mcount = 0;
    logic mis_exp = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;
    entry_t sb_q[$];

    store_narrowing_buffer_if #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH)) bus ();

    store_narrowing_buffer #(.DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane reference: byte k of the word sits at address offset k.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                  output logic ok, output entry_t e);
        e.addr = {a[31:2], 2'b00};
        e.data = '0;
        e.be   = '0;
        ok     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            case (s)
                2'b00: begin
                    e.data[8*k +: 8] = d[7:0];
                    e.be[k] = (a[1:0] == k[1:0]);
                end
                2'b01: begin
                    e.data[8*k +: 8] = (k % 2 == 1) ? d[15:8] : d[7:0];
                    e.be[k] = ((k / 2) == int'(a[1]));
                end
                2'b10: begin
                    e.data[8*k +: 8] = d[8*k +: 8];
                    e.be[k] = 1'b1;
                end
                default: ;
            endcase
        end
        case (s)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (a[0] == 1'b0);
            2'b10:   ok = (a[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        bus.i_valid = v;
        bus.i_size  = s;
        bus.i_addr  = a;
        bus.i_data  = d;
    endtask

    // One clock cycle: check outputs at the falling edge, update the model, return after the rise.
    task automatic step();
        logic   ok;
        logic   exp_ready;
        logic   take;
        logic   pop;
        entry_t e;
        @(negedge clk);
        exp_ready = (mcount < DEPTH);
        chk("ready", 32'(bus.o_ready), 32'(exp_ready));
        chk("count", 32'(bus.o_count), 32'(mcount));
        chk("empty", 32'(bus.o_empty), 32'(mcount == 0));
        chk("mem_valid", 32'(bus.o_mem_valid), 32'(mcount != 0));
        chk("misaligned", 32'(bus.o_misaligned), 32'(mis_exp));
        if (mcount > 0 && sb_q.size() > 0) begin
            chk("head_addr", bus.o_mem_addr, sb_q[0].addr);
            chk("head_data", bus.o_mem_data, sb_q[0].data);
            chk("head_be", 32'(bus.o_mem_byte_en), 32'(sb_q[0].be));
        end else begin
            chk("idle_addr", bus.o_mem_addr, 32'h0);
            chk("idle_data", bus.o_mem_data, 32'h0);
            chk("idle_be", 32'(bus.o_mem_byte_en), 32'h0);
        end
        model(bus.i_addr, bus.i_data, bus.i_size, ok, e);
        take = bus.i_valid && exp_ready;
        pop  = (mcount > 0) && bus.i_mem_ready;
        if (pop && sb_q.size() > 0) void'(sb_q.pop_front());
        if (take && ok) sb_q.push_back(e);
        mcount  = mcount + ((take && ok) ? 1 : 0) - (pop ? 1 : 0);
        mis_exp = take && !ok;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        bus.i_mem_ready = 1'b1;
        #5;
        chk("rst_ready", 32'(bus.o_ready), 32'h1);
        chk("rst_count", 32'(bus.o_count), 32'h0);
        chk("rst_empty", 32'(bus.o_empty), 32'h1);
        chk("rst_valid", 32'(bus.o_mem_valid), 32'h0);
        chk("rst_mis", 32'(bus.o_misaligned), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Word store into an empty buffer, then popped straight away.
        drive(1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sw_valid_next", 32'(bus.o_mem_valid), 32'h1);
        chk("sw_data", bus.o_mem_data, 32'hDEADBEEF);
        chk("sw_be", 32'(bus.o_mem_byte_en), 32'hF);
        step();
        chk("sw_drained_empty", 32'(bus.o_empty), 32'h1);
        chk("sw_drained_be", 32'(bus.o_mem_byte_en), 32'h0);

        // Byte and halfword lane replication.
        bus.i_mem_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h203, 32'h123456AB);
        step();
        drive(1'b1, 2'b01, 32'h202, 32'hFFFF8001);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("sb_data", bus.o_mem_data, 32'hABABABAB);
        chk("sb_be", 32'(bus.o_mem_byte_en), 32'h8);
        chk("sb_addr", bus.o_mem_addr, 32'h200);
        bus.i_mem_ready = 1'b1;
        step();
        chk("sh_data", bus.o_mem_data, 32'h80018001);
        chk("sh_be", 32'(bus.o_mem_byte_en), 32'hC);
        step();

        // Rejected stores: misaligned SH, misaligned SW, illegal size.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1'b1, 2'b01, 32'h301, 32'h1111);
                1:       drive(1'b1, 2'b10, 32'h302, 32'h2222);
                default: drive(1'b1, 2'b11, 32'h300, 32'h3333);
            endcase
            step();
            chk("reject_pulse", 32'(bus.o_misaligned), 32'h1);
            chk("reject_count", 32'(bus.o_count), 32'h0);
            chk("reject_valid", 32'(bus.o_mem_valid), 32'h0);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();

        // Fill past capacity with memory stalled; the fifth store must be refused.
        bus.i_mem_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 2'b10, 32'h400 + 32'(4 * i), 32'(i));
            step();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("full_count", 32'(bus.o_count), 32'h4);
        chk("full_ready", 32'(bus.o_ready), 32'h0);
        step();
        step();
        chk("stall_hold", bus.o_mem_data, 32'h1);
        bus.i_mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", bus.o_mem_data, 32'(i));
            step();
        end
        chk("drain_empty", 32'(bus.o_empty), 32'h1);

        // Steady push+pop at count 2 across pointer wrap.
        bus.i_mem_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h600, 32'h10);
        step();
        drive(1'b1, 2'b10, 32'h604, 32'h11);
        step();
        bus.i_mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b00, 32'h700 + 32'(i), 32'h20 + 32'(i));
            step();
            chk("pushpop_count", 32'(bus.o_count), 32'h2);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
        step();

        // Asynchronous reset with three queued stores.
        bus.i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 32'h800 + 32'(4 * i), 32'hA0 + 32'(i));
            step();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("pre_rst_count", 32'(bus.o_count), 32'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.o_mem_valid), 32'h0);
        chk("async_count", 32'(bus.o_count), 32'h0);
        chk("async_ready", 32'(bus.o_ready), 32'h1);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        mcount  = 0;
        mis_exp = 1'b0;
        drive(1'b1, 2'b10, 32'h500, 32'hCAFEF00D);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("post_rst_first", bus.o_mem_data, 32'hCAFEF00D);
        chk("post_rst_addr", bus.o_mem_addr, 32'h500);
        bus.i_mem_ready = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
